// File: rtl/axi_lite_if.sv
// axi_lite_if: AXI4-Lite channel bundle; master drives requests, slave drives responses
interface axi_lite_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDRESS_WIDTH = 4
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  logic [ADDRESS_WIDTH-1:0] awaddr;
  logic [2:0] awprot;
  logic awvalid;
  logic awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic wvalid;
  logic wready;
  logic [1:0] bresp;
  logic bvalid;
  logic bready;
  logic [ADDRESS_WIDTH-1:0] araddr;
  logic [2:0] arprot;
  logic arvalid;
  logic arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0] rresp;
  logic rvalid;
  logic rready;
  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    input awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_arbiter.sv
// axi_lite_arbiter: two-manager to one-subordinate AXI4-Lite arbiter with
// independent round-robin write and read paths, one outstanding transaction each
module axi_lite_arbiter (
  input logic clk,
  input logic rst_n,
  axi_lite_if.slave m0,
  axi_lite_if.slave m1,
  axi_lite_if.master s
);
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  w_state_t w_st;
  r_state_t r_st;
  logic w_gnt, w_last, aw_done, w_done;
  logic r_gnt, r_last;
  logic wa0, wa1, wr0, wr1, ra0, ra1, rd0, rd1;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  assign wa0 = (w_st == W_ADDR) & ~w_gnt;
  assign wa1 = (w_st == W_ADDR) & w_gnt;
  assign wr0 = (w_st == W_RESP) & ~w_gnt;
  assign wr1 = (w_st == W_RESP) & w_gnt;
  assign ra0 = (r_st == R_ADDR) & ~r_gnt;
  assign ra1 = (r_st == R_ADDR) & r_gnt;
  assign rd0 = (r_st == R_DATA) & ~r_gnt;
  assign rd1 = (r_st == R_DATA) & r_gnt;
  assign aw_hs = s.awvalid & s.awready;
  assign w_hs = s.wvalid & s.wready;
  assign b_hs = s.bvalid & s.bready;
  assign ar_hs = s.arvalid & s.arready;
  assign r_hs = s.rvalid & s.rready;
  // grant is taken only from registered state so routing never loops back into arbitration
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      w_st <= W_IDLE;
      w_gnt <= 1'b0;
      w_last <= 1'b1;
      aw_done <= 1'b0;
      w_done <= 1'b0;
    end else case (w_st)
      W_IDLE: if (m0.awvalid | m1.awvalid) begin
        w_gnt <= (m0.awvalid & m1.awvalid) ? ~w_last : m1.awvalid;
        w_st <= W_ADDR;
      end
      W_ADDR: begin
        aw_done <= aw_done | aw_hs;
        w_done <= w_done | w_hs;
        if ((aw_done | aw_hs) & (w_done | w_hs)) w_st <= W_RESP;
      end
      W_RESP: if (b_hs) begin
        w_last <= w_gnt;
        aw_done <= 1'b0;
        w_done <= 1'b0;
        w_st <= W_IDLE;
      end
      default: w_st <= W_IDLE;
    endcase
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_st <= R_IDLE;
      r_gnt <= 1'b0;
      r_last <= 1'b1;
    end else case (r_st)
      R_IDLE: if (m0.arvalid | m1.arvalid) begin
        r_gnt <= (m0.arvalid & m1.arvalid) ? ~r_last : m1.arvalid;
        r_st <= R_ADDR;
      end
      R_ADDR: if (ar_hs) r_st <= R_DATA;
      R_DATA: if (r_hs) begin
        r_last <= r_gnt;
        r_st <= R_IDLE;
      end
      default: r_st <= R_IDLE;
    endcase
  assign s.awaddr = wa1 ? m1.awaddr : wa0 ? m0.awaddr : '0;
  assign s.awprot = wa1 ? m1.awprot : wa0 ? m0.awprot : '0;
  assign s.awvalid = ~aw_done & ((wa1 & m1.awvalid) | (wa0 & m0.awvalid));
  assign s.wdata = wa1 ? m1.wdata : wa0 ? m0.wdata : '0;
  assign s.wstrb = wa1 ? m1.wstrb : wa0 ? m0.wstrb : '0;
  assign s.wvalid = ~w_done & ((wa1 & m1.wvalid) | (wa0 & m0.wvalid));
  assign s.bready = (wr1 & m1.bready) | (wr0 & m0.bready);
  assign s.araddr = ra1 ? m1.araddr : ra0 ? m0.araddr : '0;
  assign s.arprot = ra1 ? m1.arprot : ra0 ? m0.arprot : '0;
  assign s.arvalid = (ra1 & m1.arvalid) | (ra0 & m0.arvalid);
  assign s.rready = (rd1 & m1.rready) | (rd0 & m0.rready);
  assign m0.awready = wa0 & ~aw_done & s.awready;
  assign m1.awready = wa1 & ~aw_done & s.awready;
  assign m0.wready = wa0 & ~w_done & s.wready;
  assign m1.wready = wa1 & ~w_done & s.wready;
  assign m0.bvalid = wr0 & s.bvalid;
  assign m1.bvalid = wr1 & s.bvalid;
  assign m0.bresp = wr0 ? s.bresp : '0;
  assign m1.bresp = wr1 ? s.bresp : '0;
  assign m0.arready = ra0 & s.arready;
  assign m1.arready = ra1 & s.arready;
  assign m0.rvalid = rd0 & s.rvalid;
  assign m1.rvalid = rd1 & s.rvalid;
  assign m0.rdata = rd0 ? s.rdata : '0;
  assign m1.rdata = rd1 ? s.rdata : '0;
  assign m0.rresp = rd0 ? s.rresp : '0;
  assign m1.rresp = rd1 ? s.rresp : '0;
endmodule

// File: tb/tb_axi_lite_arbiter.sv
// tb_axi_lite_arbiter: directed checks of grant order, routing, split AW/W,
// concurrency, back-pressure and mid-transaction reset
module tb_axi_lite_arbiter;
  logic clk, rst_n;
  int passed = 0;
  int total = 0;
  axi_lite_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(4)) m0_if ();
  axi_lite_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(4)) m1_if ();
  axi_lite_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(4)) s_if ();
  axi_lite_arbiter dut (.clk(clk), .rst_n(rst_n), .m0(m0_if), .m1(m1_if), .s(s_if));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic clear_inputs;
    m0_if.awaddr = '0; m0_if.awprot = '0; m0_if.awvalid = 0; m0_if.wdata = '0; m0_if.wstrb = '0;
    m0_if.wvalid = 0; m0_if.bready = 0; m0_if.araddr = '0; m0_if.arprot = '0; m0_if.arvalid = 0; m0_if.rready = 0;
    m1_if.awaddr = '0; m1_if.awprot = '0; m1_if.awvalid = 0; m1_if.wdata = '0; m1_if.wstrb = '0;
    m1_if.wvalid = 0; m1_if.bready = 0; m1_if.araddr = '0; m1_if.arprot = '0; m1_if.arvalid = 0; m1_if.rready = 0;
    s_if.awready = 0; s_if.wready = 0; s_if.bresp = '0; s_if.bvalid = 0; s_if.arready = 0;
    s_if.rdata = '0; s_if.rresp = '0; s_if.rvalid = 0;
  endtask
  initial begin
    clear_inputs();
    rst_n = 0;
    tick; tick;
    chk("rst_s_awvalid", s_if.awvalid, 0);
    chk("rst_s_arvalid", s_if.arvalid, 0);
    chk("rst_s_awaddr", s_if.awaddr, 0);
    chk("rst_s_wdata", s_if.wdata, 0);
    chk("rst_m0_bvalid", m0_if.bvalid, 0);
    chk("rst_m1_rdata", m1_if.rdata, 0);
    rst_n = 1;
    // single write from m0
    m0_if.awaddr = 4'h4; m0_if.awprot = 3'b010; m0_if.awvalid = 1;
    m0_if.wdata = 32'hDEADBEEF; m0_if.wstrb = 4'hF; m0_if.wvalid = 1; m0_if.bready = 1;
    #1 chk("w1_idle_awvalid", s_if.awvalid, 0);
    tick;
    chk("w1_awvalid", s_if.awvalid, 1);
    chk("w1_awaddr", s_if.awaddr, 4'h4);
    chk("w1_awprot", s_if.awprot, 3'b010);
    chk("w1_wvalid", s_if.wvalid, 1);
    chk("w1_wdata", s_if.wdata, 32'hDEADBEEF);
    chk("w1_wstrb", s_if.wstrb, 4'hF);
    chk("w1_s_bready_addr", s_if.bready, 0);
    s_if.awready = 1; s_if.wready = 1;
    #1 chk("w1_m0_awready", m0_if.awready, 1);
    chk("w1_m0_wready", m0_if.wready, 1);
    chk("w1_m1_awready", m1_if.awready, 0);
    chk("w1_m1_wready", m1_if.wready, 0);
    tick;
    m0_if.awvalid = 0; m0_if.wvalid = 0; s_if.awready = 0; s_if.wready = 0;
    s_if.bvalid = 1; s_if.bresp = 2'b00;
    #1 chk("w1_resp_awvalid", s_if.awvalid, 0);
    chk("w1_s_bready", s_if.bready, 1);
    chk("w1_m0_bvalid", m0_if.bvalid, 1);
    chk("w1_m0_bresp", m0_if.bresp, 0);
    chk("w1_m1_bvalid", m1_if.bvalid, 0);
    tick;
    s_if.bvalid = 0;
    #1 chk("w1_idle_m0_bvalid", m0_if.bvalid, 0);
    rst_n = 0; clear_inputs(); tick; rst_n = 1;
    // simultaneous writes after reset, zero-wait subordinate
    s_if.awready = 1; s_if.wready = 1; s_if.bvalid = 1;
    m0_if.awaddr = 4'h0; m0_if.wdata = 32'h11111111; m0_if.wstrb = 4'hF;
    m0_if.awvalid = 1; m0_if.wvalid = 1; m0_if.bready = 1;
    m1_if.awaddr = 4'h8; m1_if.wdata = 32'h22222222; m1_if.wstrb = 4'hF;
    m1_if.awvalid = 1; m1_if.wvalid = 1; m1_if.bready = 1;
    tick;
    chk("w2_first_awaddr", s_if.awaddr, 4'h0);
    chk("w2_first_wdata", s_if.wdata, 32'h11111111);
    chk("w2_m0_awready", m0_if.awready, 1);
    chk("w2_m1_awready", m1_if.awready, 0);
    tick;
    m0_if.awvalid = 0; m0_if.wvalid = 0;
    #1 chk("w2_m0_bvalid", m0_if.bvalid, 1);
    chk("w2_m1_bvalid", m1_if.bvalid, 0);
    chk("w2_resp_awvalid", s_if.awvalid, 0);
    tick;
    chk("w2_idle_m0_bvalid", m0_if.bvalid, 0);
    chk("w2_idle_wvalid", s_if.wvalid, 0);
    tick;
    chk("w2_second_awaddr", s_if.awaddr, 4'h8);
    chk("w2_second_wdata", s_if.wdata, 32'h22222222);
    chk("w2_m1_wready", m1_if.wready, 1);
    chk("w2_m0_wready", m0_if.wready, 0);
    m0_if.awaddr = 4'h4; m0_if.wdata = 32'h33333333; m0_if.awvalid = 1; m0_if.wvalid = 1;
    tick;
    #1 chk("w2_m1_bvalid", m1_if.bvalid, 1);
    chk("w2_m0_bvalid_masked", m0_if.bvalid, 0);
    tick;
    tick;
    chk("w2_third_awaddr", s_if.awaddr, 4'h4);
    chk("w2_third_wdata", s_if.wdata, 32'h33333333);
    tick;
    m0_if.awvalid = 0; m0_if.wvalid = 0;
    tick;
    tick;
    chk("w2_fourth_awaddr", s_if.awaddr, 4'h8);
    tick;
    m1_if.awvalid = 0; m1_if.wvalid = 0;
    tick;
    clear_inputs();
    // split AW and W from m1
    s_if.awready = 1; s_if.wready = 1;
    m1_if.awaddr = 4'hC; m1_if.awvalid = 1; m1_if.wdata = 32'h55; m1_if.wstrb = 4'h3; m1_if.bready = 1;
    tick;
    chk("w3_awvalid", s_if.awvalid, 1);
    chk("w3_wvalid_early", s_if.wvalid, 0);
    tick;
    m1_if.awvalid = 0;
    #1 chk("w3_awvalid_done", s_if.awvalid, 0);
    tick;
    chk("w3_m1_awready_done", m1_if.awready, 0);
    chk("w3_s_bready_wait", s_if.bready, 0);
    m1_if.wvalid = 1;
    #1 chk("w3_wvalid", s_if.wvalid, 1);
    chk("w3_wdata", s_if.wdata, 32'h55);
    chk("w3_m1_wready", m1_if.wready, 1);
    tick;
    m1_if.wvalid = 0; s_if.bvalid = 1; s_if.bresp = 2'b10;
    #1 chk("w3_s_bready", s_if.bready, 1);
    chk("w3_m1_bvalid", m1_if.bvalid, 1);
    chk("w3_m1_bresp", m1_if.bresp, 2'b10);
    chk("w3_m0_bresp", m0_if.bresp, 0);
    tick;
    clear_inputs();
    // concurrent read by m1 and write by m0
    s_if.awready = 1; s_if.wready = 1; s_if.arready = 1;
    m0_if.awaddr = 4'hC; m0_if.wdata = 32'h77; m0_if.wstrb = 4'hF;
    m0_if.awvalid = 1; m0_if.wvalid = 1; m0_if.bready = 1;
    m1_if.araddr = 4'hC; m1_if.arprot = 3'b001; m1_if.arvalid = 1; m1_if.rready = 1;
    tick;
    chk("c_awvalid", s_if.awvalid, 1);
    chk("c_arvalid", s_if.arvalid, 1);
    chk("c_araddr", s_if.araddr, 4'hC);
    chk("c_arprot", s_if.arprot, 3'b001);
    chk("c_awaddr", s_if.awaddr, 4'hC);
    chk("c_m1_arready", m1_if.arready, 1);
    chk("c_m0_arready", m0_if.arready, 0);
    chk("c_m1_awready", m1_if.awready, 0);
    tick;
    m0_if.awvalid = 0; m0_if.wvalid = 0; m1_if.arvalid = 0;
    s_if.rvalid = 1; s_if.rdata = 32'hCAFEF00D; s_if.rresp = 2'b01; s_if.bvalid = 1;
    #1 chk("c_m1_rvalid", m1_if.rvalid, 1);
    chk("c_m1_rdata", m1_if.rdata, 32'hCAFEF00D);
    chk("c_m1_rresp", m1_if.rresp, 2'b01);
    chk("c_m0_rdata", m0_if.rdata, 0);
    chk("c_m0_rvalid", m0_if.rvalid, 0);
    chk("c_m0_bvalid", m0_if.bvalid, 1);
    chk("c_m1_bvalid", m1_if.bvalid, 0);
    chk("c_s_rready", s_if.rready, 1);
    tick;
    clear_inputs();
    // read back-pressure on m0
    s_if.arready = 1;
    m0_if.araddr = 4'h4; m0_if.arvalid = 1; m0_if.rready = 0;
    tick;
    chk("bp_araddr", s_if.araddr, 4'h4);
    tick;
    m0_if.arvalid = 0; s_if.rvalid = 1; s_if.rdata = 32'h12345678;
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp_s_rready", s_if.rready, 0);
      chk("bp_m0_rvalid", m0_if.rvalid, 1);
      chk("bp_m0_rdata", m0_if.rdata, 32'h12345678);
      tick;
    end
    m0_if.rready = 1;
    #1 chk("bp_s_rready_rel", s_if.rready, 1);
    tick;
    s_if.rvalid = 0;
    #1 chk("bp_idle_rvalid", m0_if.rvalid, 0);
    clear_inputs();
    // reset during write response
    s_if.awready = 1; s_if.wready = 1;
    m0_if.awaddr = 4'h2; m0_if.awvalid = 1; m0_if.wvalid = 1; m0_if.bready = 1;
    tick;
    tick;
    m0_if.awvalid = 0; m0_if.wvalid = 0; s_if.bvalid = 1;
    #1 chk("rm_m0_bvalid", m0_if.bvalid, 1);
    rst_n = 0;
    #1 chk("rm_m0_bvalid_rst", m0_if.bvalid, 0);
    chk("rm_s_bready_rst", s_if.bready, 0);
    s_if.bvalid = 0;
    m0_if.awaddr = 4'h6; m0_if.awvalid = 1; m0_if.wvalid = 1;
    m1_if.awaddr = 4'hA; m1_if.awvalid = 1; m1_if.wvalid = 1;
    tick;
    chk("rm_held_awvalid", s_if.awvalid, 0);
    rst_n = 1;
    tick;
    chk("rm_grant_awaddr", s_if.awaddr, 4'h6);
    chk("rm_m0_awready", m0_if.awready, 1);
    chk("rm_m1_awready", m1_if.awready, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
